// File: rtl/pipe_issue_ctrl_pkg.sv
// Shared field widths, opcode constants and the instruction record used by
// the issue scheduler and its instruction buffer.
package pipe_pkg;

   localparam int REG_W  = 4;
   localparam int FN_W   = 4;
   localparam int ADDR_W = 8;
   localparam int DATA_W = 16;

   // NOT, INC, DEC and SHL read only rs1, but the hazard check still compares both sources.
   localparam logic [FN_W-1:0] FN_ADD       = 4'd0;
   localparam logic [FN_W-1:0] FN_SUB       = 4'd1;
   localparam logic [FN_W-1:0] FN_AND       = 4'd2;
   localparam logic [FN_W-1:0] FN_NOT       = 4'd3;
   localparam logic [FN_W-1:0] FN_OR        = 4'd4;
   localparam logic [FN_W-1:0] FN_XOR       = 4'd5;
   localparam logic [FN_W-1:0] FN_LD        = 4'd6;
   localparam logic [FN_W-1:0] FN_ST        = 4'd7;
   localparam logic [FN_W-1:0] FN_INC       = 4'd8;
   localparam logic [FN_W-1:0] FN_CMP       = 4'd9;
   localparam logic [FN_W-1:0] FN_DEC       = 4'd10;
   localparam logic [FN_W-1:0] FN_SHL       = 4'd11;
   localparam logic [FN_W-1:0] FN_MAX_LEGAL = FN_SHL;

   typedef struct packed {
      logic [REG_W-1:0]  rs1;
      logic [REG_W-1:0]  rs2;
      logic [REG_W-1:0]  rd;
      logic [FN_W-1:0]   func;
      logic [ADDR_W-1:0] addr;
   } instr_t;

   function automatic logic is_illegal(input logic [FN_W-1:0] func);
      return func > FN_MAX_LEGAL;
   endfunction

endpackage

// File: rtl/pipe_issue_ctrl_fifo.sv
// In-order instruction buffer. Flush clears the buffer and wins over any
// push or pop in the same cycle.
module pipe_instr_fifo
   import pipe_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic                     pop,
   input  logic                     flush,
   input  instr_t                   wdata,
   output instr_t                   rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PTR_W = $clog2(DEPTH);

   instr_t           mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == (PTR_W+1)'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full && !flush;
   assign do_pop  = pop && !empty && !flush;
   assign rdata   = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (!rst_n || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

endmodule

// File: rtl/pipe_issue_ctrl.sv
// Issue scheduler: buffers instructions, holds the head on a RAW hazard
// against the recent-issue window, drops illegal opcodes, issues one per cycle.
module pipe_issue_ctrl
   import pipe_pkg::*;
#(
   parameter int FIFO_DEPTH = 4,
   parameter int HAZ_DEPTH  = 2,
   parameter int CNT_W      = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [REG_W-1:0]  in_rs1,
   input  logic [REG_W-1:0]  in_rs2,
   input  logic [REG_W-1:0]  in_rd,
   input  logic [FN_W-1:0]   in_func,
   input  logic [ADDR_W-1:0] in_addr,
   input  logic              flush,
   output logic              iss_valid,
   output logic [REG_W-1:0]  iss_rs1,
   output logic [REG_W-1:0]  iss_rs2,
   output logic [REG_W-1:0]  iss_rd,
   output logic [FN_W-1:0]   iss_func,
   output logic [ADDR_W-1:0] iss_addr,
   output logic              err_illegal,
   output logic              idle,
   output logic [CNT_W-1:0]  issue_cnt,
   output logic [CNT_W-1:0]  stall_cnt
);

   instr_t                        in_instr;
   instr_t                        head;
   logic                          fifo_full;
   logic                          fifo_empty;
   logic [$clog2(FIFO_DEPTH):0]   fifo_count;
   logic                          push;
   logic                          pop;
   logic                          head_live;
   logic                          head_illegal;
   logic                          hazard;
   logic                          do_issue;
   logic                          do_drop;
   logic                          do_stall;

   // Entry 0 always mirrors the iss_* register; older entries shift behind it (HAZ_DEPTH >= 2).
   logic [HAZ_DEPTH-1:0]          hist_valid;
   logic [REG_W-1:0]              hist_rd [HAZ_DEPTH];

   assign in_instr = '{rs1: in_rs1, rs2: in_rs2, rd: in_rd, func: in_func, addr: in_addr};
   assign in_ready = rst_n && !fifo_full;
   assign push     = in_valid && in_ready;

   pipe_instr_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .pop   (pop),
      .flush (flush),
      .wdata (in_instr),
      .rdata (head),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   always_comb begin
      hazard = 1'b0;
      for (int i = 0; i < HAZ_DEPTH; i++) begin
         if (hist_valid[i] && ((hist_rd[i] == head.rs1) || (hist_rd[i] == head.rs2))) begin
            hazard = 1'b1;
         end
      end
   end

   assign head_live    = !fifo_empty && !flush;
   assign head_illegal = is_illegal(head.func);
   assign do_drop      = head_live && head_illegal;
   assign do_stall     = head_live && !head_illegal && hazard;
   assign do_issue     = head_live && !head_illegal && !hazard;
   assign pop          = do_drop || do_issue;

   assign idle = (fifo_count == '0) && (hist_valid == '0) && !iss_valid;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         iss_valid   <= 1'b0;
         iss_rs1     <= '0;
         iss_rs2     <= '0;
         iss_rd      <= '0;
         iss_func    <= '0;
         iss_addr    <= '0;
         err_illegal <= 1'b0;
      end else begin
         iss_valid   <= do_issue;
         err_illegal <= do_drop;
         if (do_issue) begin
            iss_rs1  <= head.rs1;
            iss_rs2  <= head.rs2;
            iss_rd   <= head.rd;
            iss_func <= head.func;
            iss_addr <= head.addr;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         hist_valid <= '0;
         for (int i = 0; i < HAZ_DEPTH; i++) hist_rd[i] <= '0;
      end else begin
         hist_valid <= {hist_valid[HAZ_DEPTH-2:0], do_issue};
         hist_rd[0] <= head.rd;
         for (int i = 1; i < HAZ_DEPTH; i++) hist_rd[i] <= hist_rd[i-1];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         issue_cnt <= '0;
         stall_cnt <= '0;
      end else begin
         if (do_issue) issue_cnt <= issue_cnt + 1'b1;
         if (do_stall) stall_cnt <= stall_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_pipe_issue_ctrl.sv
// Directed bench for pipe_issue_ctrl: streams, RAW spacing, illegal drops,
// full-buffer backpressure, flush and mid-stream reset.
module tb_pipe_issue_ctrl;
   import pipe_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  in_rs1, in_rs2, in_rd, in_func;
   logic [7:0]  in_addr;
   logic        flush;
   logic        iss_valid;
   logic [3:0]  iss_rs1, iss_rs2, iss_rd, iss_func;
   logic [7:0]  iss_addr;
   logic        err_illegal;
   logic        idle;
   logic [15:0] issue_cnt, stall_cnt;

   pipe_issue_ctrl #(.FIFO_DEPTH(4), .HAZ_DEPTH(2), .CNT_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_func(in_func), .in_addr(in_addr),
      .flush(flush), .iss_valid(iss_valid), .iss_rs1(iss_rs1), .iss_rs2(iss_rs2),
      .iss_rd(iss_rd), .iss_func(iss_func), .iss_addr(iss_addr), .err_illegal(err_illegal),
      .idle(idle), .issue_cnt(issue_cnt), .stall_cnt(stall_cnt)
   );

   always #5 clk = ~clk;

   int         checks = 0;
   int         errors = 0;
   int         cyc = 0;
   int         b;
   int         e;
   logic       log_v   [0:1023];
   logic [3:0] log_rd  [0:1023];
   logic       log_err [0:1023];
   logic [15:0] ic0, sc0;

   task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   // Outputs are sampled 1ns after each rising edge and logged by cycle index.
   task automatic tick();
      @(posedge clk);
      #1;
      log_v[cyc]   = iss_valid;
      log_rd[cyc]  = iss_rd;
      log_err[cyc] = err_illegal;
      cyc++;
   endtask

   task automatic applyStimulus(input logic v, input logic [3:0] rs1, input logic [3:0] rs2,
                                input logic [3:0] rd, input logic [3:0] func);
      in_valid = v;
      in_rs1   = rs1;
      in_rs2   = rs2;
      in_rd    = rd;
      in_func  = func;
      in_addr  = {func, rd};
   endtask

   task automatic pushOne(input logic [3:0] rs1, input logic [3:0] rs2,
                          input logic [3:0] rd, input logic [3:0] func);
      applyStimulus(1'b1, rs1, rs2, rd, func);
      tick();
   endtask

   task automatic idleCycles(input int n);
      applyStimulus(1'b0, 4'd0, 4'd0, 4'd0, 4'd0);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic snap();
      b   = cyc;
      ic0 = issue_cnt;
      sc0 = stall_cnt;
   endtask

   initial begin
      rst_n = 1'b0;
      flush = 1'b0;
      applyStimulus(1'b0, 4'd0, 4'd0, 4'd0, 4'd0);
      tick();
      tick();
      $display("[TB] reset state");
      checkOutput("rst_in_ready", in_ready, 0);
      checkOutput("rst_iss_valid", iss_valid, 0);
      checkOutput("rst_idle", idle, 1);
      checkOutput("rst_issue_cnt", issue_cnt, 0);
      checkOutput("rst_stall_cnt", stall_cnt, 0);
      rst_n = 1'b1;
      #1;
      checkOutput("post_rst_in_ready", in_ready, 1);

      $display("[TB] independent stream");
      snap();
      pushOne(4'd1, 4'd2, 4'd3, FN_ADD);
      pushOne(4'd4, 4'd5, 4'd6, FN_SUB);
      pushOne(4'd7, 4'd8, 4'd9, FN_AND);
      idleCycles(3);
      checkOutput("ind_v0", log_v[b], 0);
      checkOutput("ind_v1", log_v[b+1], 1);
      checkOutput("ind_rd1", log_rd[b+1], 3);
      checkOutput("ind_v2", log_v[b+2], 1);
      checkOutput("ind_rd2", log_rd[b+2], 6);
      checkOutput("ind_v3", log_v[b+3], 1);
      checkOutput("ind_rd3", log_rd[b+3], 9);
      checkOutput("ind_v4", log_v[b+4], 0);
      checkOutput("ind_hold_rd", log_rd[b+4], 9);
      checkOutput("ind_hold_addr", iss_addr, 8'h29);
      checkOutput("ind_hold_func", iss_func, FN_AND);
      checkOutput("ind_issue_cnt", issue_cnt, 3);
      checkOutput("ind_stall_cnt", stall_cnt, 0);
      checkOutput("ind_idle", idle, 1);

      $display("[TB] RAW chain");
      snap();
      pushOne(4'd1, 4'd2, 4'd3, FN_ADD);
      pushOne(4'd3, 4'd4, 4'd5, FN_SUB);
      idleCycles(5);
      checkOutput("raw_v1", log_v[b+1], 1);
      checkOutput("raw_rd1", log_rd[b+1], 3);
      checkOutput("raw_v2", log_v[b+2], 0);
      checkOutput("raw_v3", log_v[b+3], 0);
      checkOutput("raw_v4", log_v[b+4], 1);
      checkOutput("raw_rd4", log_rd[b+4], 5);
      checkOutput("raw_stalls", 16'(stall_cnt - sc0), 2);
      checkOutput("raw_issues", 16'(issue_cnt - ic0), 2);

      $display("[TB] single-operand op still checks rs2");
      snap();
      pushOne(4'd1, 4'd2, 4'd7, FN_ADD);
      pushOne(4'd1, 4'd7, 4'd8, FN_NOT);
      idleCycles(5);
      checkOutput("one_op_v2", log_v[b+2], 0);
      checkOutput("one_op_v4", log_v[b+4], 1);
      checkOutput("one_op_rd4", log_rd[b+4], 8);
      checkOutput("one_op_stalls", 16'(stall_cnt - sc0), 2);

      $display("[TB] producer beyond window");
      snap();
      pushOne(4'd1, 4'd2, 4'd3, FN_ADD);
      pushOne(4'd4, 4'd5, 4'd6, FN_SUB);
      pushOne(4'd7, 4'd8, 4'd9, FN_OR);
      pushOne(4'd1, 4'd3, 4'd10, FN_XOR);
      idleCycles(4);
      checkOutput("win_rd1", log_rd[b+1], 3);
      checkOutput("win_rd2", log_rd[b+2], 6);
      checkOutput("win_rd3", log_rd[b+3], 9);
      checkOutput("win_v4", log_v[b+4], 1);
      checkOutput("win_rd4", log_rd[b+4], 10);
      checkOutput("win_stalls", 16'(stall_cnt - sc0), 0);

      $display("[TB] illegal opcode");
      snap();
      pushOne(4'd1, 4'd2, 4'd4, FN_ADD);
      pushOne(4'd1, 4'd2, 4'd7, 4'd13);
      pushOne(4'd8, 4'd9, 4'd11, FN_ADD);
      idleCycles(4);
      checkOutput("ill_v1", log_v[b+1], 1);
      checkOutput("ill_err1", log_err[b+1], 0);
      checkOutput("ill_v2", log_v[b+2], 0);
      checkOutput("ill_err2", log_err[b+2], 1);
      checkOutput("ill_err3", log_err[b+3], 0);
      checkOutput("ill_v3", log_v[b+3], 1);
      checkOutput("ill_rd3", log_rd[b+3], 11);
      checkOutput("ill_issues", 16'(issue_cnt - ic0), 2);
      checkOutput("ill_stalls", 16'(stall_cnt - sc0), 0);

      $display("[TB] fill while stalled");
      snap();
      pushOne(4'd1, 4'd2, 4'd3, FN_ADD);
      checkOutput("full_rdy0", in_ready, 1);
      pushOne(4'd3, 4'd0, 4'd4, FN_ADD);
      pushOne(4'd4, 4'd0, 4'd5, FN_SUB);
      pushOne(4'd5, 4'd0, 4'd6, FN_INC);
      pushOne(4'd6, 4'd0, 4'd7, FN_DEC);
      checkOutput("full_rdy4", in_ready, 1);
      pushOne(4'd8, 4'd9, 4'd8, FN_ADD);
      checkOutput("full_rdy5", in_ready, 0);
      pushOne(4'd10, 4'd11, 4'd1, FN_ADD);
      checkOutput("full_rdy6", in_ready, 0);
      idleCycles(1);
      checkOutput("full_rdy7", in_ready, 1);
      idleCycles(10);
      checkOutput("full_rd_p", log_rd[b+1], 3);
      checkOutput("full_v5", log_v[b+5], 0);
      checkOutput("full_rd_c1", log_rd[b+4], 4);
      checkOutput("full_rd_c2", log_rd[b+7], 5);
      checkOutput("full_rd_c3", log_rd[b+10], 6);
      checkOutput("full_rd_c4", log_rd[b+13], 7);
      checkOutput("full_v_c5", log_v[b+14], 1);
      checkOutput("full_rd_c5", log_rd[b+14], 8);
      checkOutput("full_no_extra", log_v[b+15], 0);
      checkOutput("full_issues", 16'(issue_cnt - ic0), 6);
      checkOutput("full_stalls", 16'(stall_cnt - sc0), 8);
      checkOutput("full_drained_rdy", in_ready, 1);

      $display("[TB] flush");
      snap();
      pushOne(4'd1, 4'd2, 4'd3, FN_ADD);
      pushOne(4'd3, 4'd0, 4'd4, FN_ADD);
      pushOne(4'd8, 4'd9, 4'd10, FN_OR);
      pushOne(4'd11, 4'd12, 4'd13, FN_XOR);
      pushOne(4'd14, 4'd15, 4'd12, FN_AND);
      checkOutput("fl_inflight_v", iss_valid, 1);
      checkOutput("fl_inflight_rd", iss_rd, 4);
      applyStimulus(1'b1, 4'd1, 4'd1, 4'd2, FN_ADD);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      checkOutput("fl_v_after", iss_valid, 0);
      checkOutput("fl_idle_1", idle, 0);
      idleCycles(1);
      checkOutput("fl_idle_2", idle, 1);
      idleCycles(4);
      for (int i = 5; i <= 10; i++) checkOutput($sformatf("fl_quiet_%0d", i), log_v[b+i], 0);
      checkOutput("fl_hold_rd", iss_rd, 4);
      checkOutput("fl_issues", 16'(issue_cnt - ic0), 2);
      checkOutput("fl_stalls", 16'(stall_cnt - sc0), 2);

      $display("[TB] mid-stream reset");
      pushOne(4'd1, 4'd2, 4'd3, FN_ADD);
      pushOne(4'd1, 4'd2, 4'd4, FN_SUB);
      applyStimulus(1'b0, 4'd0, 4'd0, 4'd0, 4'd0);
      rst_n = 1'b0;
      tick();
      checkOutput("mr_iss_valid", iss_valid, 0);
      checkOutput("mr_iss_rd", iss_rd, 0);
      checkOutput("mr_iss_rs1", iss_rs1, 0);
      checkOutput("mr_iss_addr", iss_addr, 0);
      checkOutput("mr_err", err_illegal, 0);
      checkOutput("mr_issue_cnt", issue_cnt, 0);
      checkOutput("mr_stall_cnt", stall_cnt, 0);
      checkOutput("mr_in_ready", in_ready, 0);
      checkOutput("mr_idle", idle, 1);
      rst_n = 1'b1;
      e = cyc;
      pushOne(4'd3, 4'd4, 4'd5, FN_ADD);
      idleCycles(3);
      checkOutput("mr_post_v", log_v[e+1], 1);
      checkOutput("mr_post_rd", log_rd[e+1], 5);
      checkOutput("mr_post_issue", issue_cnt, 1);
      checkOutput("mr_post_stall", stall_cnt, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
